sound_arbiter: RTL
==================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter DUR_CYCLES, default 1200000, tone length in clk cycles (100 ms at 12 MHz); legal range 1..2^24-1.
REQ-002 Parameter GAP_CYCLES, default 120000, silent gap after each tone in clk cycles; legal range 1..2^24-1.
REQ-003 clk  input  1  system clock, 12 MHz; all state changes on its rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  sound request per event source, one bit per requester; single-cycle pulse or level, either accepted.
REQ-006 code_sound  output  2  index of the requester being played, feeds the sound controller.
REQ-007 mute  output  1  high = silence; low only while a tone is playing.
REQ-008 grant  output  4  one-hot, one-cycle pulse in the first PLAY cycle of each tone.
REQ-009 busy  output  1  high in PLAY and GAP states.

Function
REQ-010 Each req bit shall set a sticky pending bit on the clock edge where it is sampled high.
REQ-011 The candidate set is pending OR req; arbitration uses this set so a request reaches PLAY with one-edge latency.
REQ-012 States: IDLE, PLAY, GAP; all outputs are registered.
REQ-013 IDLE: candidate set non-zero -> PLAY at the same edge, with winner selected and grant loaded; otherwise stay IDLE.
REQ-014 On entry to PLAY: code_sound = winner index, mute = 0, busy = 1, winner pending bit cleared, duration counter loaded.
REQ-015 PLAY shall last exactly DUR_CYCLES cycles, then enter GAP with mute = 1 and code_sound holding its last value.
REQ-016 GAP shall last exactly GAP_CYCLES cycles.
REQ-017 At the final GAP edge: candidate set non-zero -> PLAY directly with no IDLE cycle; otherwise IDLE with busy = 0.
REQ-018 Simultaneous set and clear of the same pending bit: set wins; the requester is replayed later.
REQ-019 Requests arriving during PLAY or GAP are retained; requests are never lost and never counted more than once per bit.
REQ-020 Down-counter is 24 bits and never wraps: it reloads on each state entry and compares against 1.
REQ-021 grant shall be 0 in every cycle except the first PLAY cycle.

Reset
REQ-022 While clr is high at an edge: state = IDLE, pending = 0, counter = 0, rr pointer = 0, mute = 1, code_sound = 0, grant = 0, busy = 0.
REQ-023 clr asserted mid-PLAY or mid-GAP shall abort immediately, with no residual tone and all pending requests discarded.
REQ-024 clr has priority over req in the same cycle.

Configuration
REQ-025 Macro SOUND_ARBITER_RR_EN defined: round-robin arbitration; search starts at the index after the last winner (mod 4); pointer updates on each grant.
REQ-026 Macro SOUND_ARBITER_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Verification
(Bench uses DUR_CYCLES=4, GAP_CYCLES=2.)
REQ-027 Reset then idle -> mute=1, busy=0, grant=0, code_sound=0 indefinitely.
REQ-028 req=0010 pulse at edge E -> after E: grant=0010 for 1 cycle, code_sound=1, mute=0 for 4 cycles, then mute=1 for 2 cycles, then busy=0.
REQ-029 req=1111 single pulse -> four tones back-to-back separated only by 2-cycle gaps, with no IDLE cycle between them. RR build order: 0,1,2,3. Fixed-priority build order: 0,1,2,3.
REQ-030 RR build: bit 0 held high continuously plus a bit 2 pulse -> order 0,2,0,... Fixed-priority build: bit 2 is starved while bit 0 is held.
REQ-031 req bit 3 pulsed again in the first PLAY cycle of its own tone -> pending set wins; bit 3 replays after the gap.
REQ-032 clr asserted in the second PLAY cycle with bit 1 pending -> next cycle mute=1, busy=0, state IDLE; bit 1 is never played.

Source files
------------

// File: rtl/sound_arbiter.sv
// sound_arbiter: arbitrates four sound requesters onto one tone generator.
// Each granted tone plays for DUR_CYCLES clocks, followed by a silent gap of
// GAP_CYCLES clocks. Requests are latched as sticky pending bits so none are
// lost while a tone or gap is in progress.
// Optional macro SOUND_ARBITER_RR_EN: round-robin arbitration instead of the
// default fixed priority (lowest index wins).
module sound_arbiter #(
    parameter int unsigned DUR_CYCLES = 1200000,
    parameter int unsigned GAP_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] req,
    output logic [1:0] code_sound,
    output logic       mute,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [23:0] DUR_LOAD = 24'(DUR_CYCLES);
    localparam logic [23:0] GAP_LOAD = 24'(GAP_CYCLES);

    state_t      state_q;
    logic [3:0]  pend_q;
    logic [3:0]  pend_d;
    logic [23:0] cnt_q;
    logic [1:0]  code_q;
    logic        mute_q;
    logic [3:0]  grant_q;
    logic        busy_q;

    logic [3:0]  cand;
    logic [1:0]  win_idx;
    logic [3:0]  win_mask;
    logic        start_play;

`ifdef SOUND_ARBITER_RR_EN
    // ptr_q holds the index where the next search begins (last winner + 1).
    logic [1:0]  ptr_q;
    logic [1:0]  scan_idx;
`endif

    // Requests sampled this edge count immediately, giving one-edge latency.
    assign cand = pend_q | req;

    // Winner selection: the search loop runs from the far end so the
    // candidate closest to the search start overwrites the others.
    always_comb begin
        win_idx = 2'd0;
`ifdef SOUND_ARBITER_RR_EN
        scan_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (cand[scan_idx]) win_idx = scan_idx;
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (cand[k]) win_idx = 2'(k);
        end
`endif
        win_mask = (cand != 4'b0000) ? (4'b0001 << win_idx) : 4'b0000;
    end

    // A new tone starts from IDLE, or straight from the last GAP cycle.
    always_comb begin
        start_play = 1'b0;
        if (cand != 4'b0000) begin
            if (state_q == IDLE) start_play = 1'b1;
            if (state_q == GAP && cnt_q == 24'd1) start_play = 1'b1;
        end
    end

    // Pending bits: requests sampled on a later edge always set their bit,
    // so a requester that asks again during its own tone is replayed. The
    // request that is consumed by the grant on this very edge is not kept.
    always_comb begin
        pend_d = pend_q | req;
        if (start_play) pend_d = (pend_q | req) & ~win_mask;
    end

    // Main FSM with registered outputs; clr aborts everything at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            cnt_q   <= 24'd0;
            code_q  <= 2'd0;
            mute_q  <= 1'b1;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
`ifdef SOUND_ARBITER_RR_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            pend_q  <= pend_d;
            grant_q <= 4'b0000;
            if (start_play) begin
                state_q <= PLAY;
                code_q  <= win_idx;
                mute_q  <= 1'b0;
                busy_q  <= 1'b1;
                grant_q <= win_mask;
                cnt_q   <= DUR_LOAD;
`ifdef SOUND_ARBITER_RR_EN
                ptr_q   <= win_idx + 2'd1;
`endif
            end else begin
                case (state_q)
                    PLAY: begin
                        if (cnt_q == 24'd1) begin
                            state_q <= GAP;
                            mute_q  <= 1'b1;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            cnt_q <= cnt_q - 24'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_q == 24'd1) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= 24'd0;
                        end else begin
                            cnt_q <= cnt_q - 24'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        mute_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign code_sound = code_q;
    assign mute       = mute_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule
